// File: rtl/stepmotor_pkg.sv
// Shared state encoding and 50 MHz timing defaults for the step/dir motor driver.
package stepmotor_pkg;

   localparam int PULSE_W_DEF    = 100;   // 2 us step high time
   localparam int DIR_SETUP_DEF  = 250;   // 5 us dir-to-step setup
   localparam int MIN_PERIOD_DEF = 200;   // fastest allowed step period
   localparam int POS_W          = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } step_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pos_counter.sv
// Signed up/down step counter; wraps naturally at the 32-bit two's complement limits.
module pos_counter
   import stepmotor_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    step,
   input  logic                    up,
   output logic signed [POS_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (step)
         count <= up ? count + 32'sd1 : count - 32'sd1;
   end

endmodule

// File: rtl/step_pulse_gen.sv
// Step/dir pulse generator: one shared down-counter times dir setup, step high and step low.
module step_pulse_gen
   import stepmotor_pkg::*;
#(
   parameter int WIDTH_WORK = 16,
   parameter int PULSE_W    = PULSE_W_DEF,
   parameter int DIR_SETUP  = DIR_SETUP_DEF,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    dir_in,
   input  logic [WIDTH_WORK-1:0]   period,
   output logic                    drv_step,
   output logic                    drv_dir,
   output logic                    busy,
   output logic                    step_done,
   output logic signed [POS_W-1:0] position
);

   localparam int TW = max2(max2(WIDTH_WORK, $clog2(DIR_SETUP + 1)), $clog2(PULSE_W + 1));
   localparam logic [TW-1:0]         SETUP_LD = TW'(DIR_SETUP - 1);
   localparam logic [TW-1:0]         HIGH_LD  = TW'(PULSE_W - 1);
   localparam logic [TW-1:0]         LOW_OFS  = TW'(PULSE_W + 1);
   localparam logic [TW-1:0]         ONE      = TW'(1);
   localparam logic [WIDTH_WORK-1:0] MIN_PER  = WIDTH_WORK'(MIN_PERIOD);

   step_state_e           state;
   logic [TW-1:0]         timer;
   logic [WIDTH_WORK-1:0] per;
   logic [WIDTH_WORK-1:0] per_clamped;
   logic                  timer_zero;
   logic                  run_req;
   logic                  go_high;

   assign timer_zero  = (timer == '0);
   assign run_req     = enable && (period != '0);
   assign per_clamped = (period < MIN_PER) ? MIN_PER : period;

   // HIGH entry is shared by the FSM and the position counter so both move on the same edge.
   always_comb begin
      go_high = 1'b0;
      case (state)
         ST_SETUP: go_high = enable && timer_zero;
         ST_LOW:   go_high = run_req && timer_zero && (dir_in == drv_dir);
         default:  go_high = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         timer     <= '0;
         per       <= '0;
         drv_step  <= 1'b0;
         drv_dir   <= 1'b0;
         busy      <= 1'b0;
         step_done <= 1'b0;
      end else begin
         step_done <= 1'b0;
         if (go_high) begin
            state     <= ST_HIGH;
            per       <= per_clamped;
            timer     <= HIGH_LD;
            drv_step  <= 1'b1;
            busy      <= 1'b1;
            step_done <= (PULSE_W == 1);
         end else begin
            case (state)
               ST_IDLE: begin
                  if (run_req) begin
                     state   <= ST_SETUP;
                     drv_dir <= dir_in;
                     timer   <= SETUP_LD;
                     busy    <= 1'b1;
                  end
               end
               ST_SETUP: begin
                  if (!enable) begin
                     state <= ST_IDLE;
                     timer <= '0;
                     busy  <= 1'b0;
                  end else begin
                     timer <= timer - ONE;
                  end
               end
               // The pulse always runs to full width; enable/period are not looked at here.
               ST_HIGH: begin
                  if (timer_zero) begin
                     state    <= ST_LOW;
                     drv_step <= 1'b0;
                     timer    <= TW'(per) - LOW_OFS;
                  end else begin
                     timer     <= timer - ONE;
                     step_done <= (timer == ONE);
                  end
               end
               ST_LOW: begin
                  if (!enable || (timer_zero && period == '0)) begin
                     state <= ST_IDLE;
                     timer <= '0;
                     busy  <= 1'b0;
                  end else if (timer_zero) begin
                     // Direction change: re-run the setup window before the next pulse.
                     state   <= ST_SETUP;
                     drv_dir <= dir_in;
                     timer   <= SETUP_LD;
                  end else begin
                     timer <= timer - ONE;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   pos_counter u_pos (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (go_high),
      .up    (drv_dir),
      .count (position)
   );

endmodule
